muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters: none; all data widths are fixed at 32 bits.
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request strobe; sampled only at rising edges where busy=0.
REQ-005 opcode  input  3  operation select, RISC-V M funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 A  input  32  operand rs1 (dividend / multiplicand).
REQ-007 B  input  32  operand rs2 (divisor / multiplier).
REQ-008 busy  output  1  high from the edge accepting start through the edge that asserts done.
REQ-009 done  output  1  one-cycle result-valid pulse.
REQ-010 Y  output  32  registered result; holds its value until the next done.
REQ-011 zero  output  1  registered flag, equal to (Y == 0), updated together with Y.

Function
REQ-012 Operands and opcode SHALL be captured at the accepting edge (edge k); later input changes SHALL NOT affect the operation in flight.
REQ-013 States: IDLE, MUL, DIV, FIX, DONE.
- IDLE + start: go to MUL (opcode[2]=0) or DIV (opcode[2]=1).
- DONE: lasts one cycle, then returns to IDLE.
REQ-014 start during busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-015 start in the DONE cycle SHALL be accepted, so back-to-back operations are possible.
REQ-016 MUL and DIV SHALL each iterate exactly 32 cycles, one bit per cycle, using a 6-bit iteration counter.
REQ-017 Multiply SHALL be shift-add on operand magnitudes; signed operands SHALL be converted to magnitudes at capture, with the result sign applied in FIX.
- MUL: low 32 bits of the 64-bit product.
- MULH: high 32 bits, signed x signed.
- MULHSU: high 32 bits, A signed x B unsigned.
- MULHU: high 32 bits, unsigned x unsigned.
REQ-018 Divide SHALL be restoring division on magnitudes.
- DIV/REM: signed; quotient truncates toward zero; remainder takes the sign of A.
- DIVU/REMU: unsigned.
REQ-019 FIX SHALL apply sign correction and result selection, then load Y and zero.
REQ-020 Normal latency: done=1 and Y valid in the cycle following edge k+33; busy=1 from edge k through edge k+33.
REQ-021 Divide by zero (B=0, any divide opcode) SHALL bypass DIV and FIX, with done at edge k+1.
- Quotient = 0xFFFFFFFF.
- Remainder = A.
REQ-022 Signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF) SHALL take the same fast path as REQ-021.
- Quotient = 0x80000000.
- Remainder = 0.
REQ-023 Multiply SHALL have no fast path, including operands of 0.
REQ-024 done SHALL be high for exactly one cycle per accepted start.
REQ-025 Y and zero SHALL change only at the edge that asserts done, or on reset.

Reset
REQ-026 Asserting reset SHALL immediately force: state=IDLE, busy=0, done=0, Y=0, zero=1, counter=0, all internal operand/accumulator registers=0.
REQ-027 Reset asserted mid-operation SHALL abort that operation with no done pulse.
REQ-028 The first edge after reset deasserts SHALL accept a start.

Verification
REQ-029 MUL A=3, B=4, start at edge k -> done at edge k+33, Y=0x0000000C, zero=0.
REQ-030 MULH A=0x80000000, B=0x80000000 -> Y=0x40000000; MULHU with the same operands -> Y=0x40000000; MULHSU A=0xFFFFFFFF, B=2 -> Y=0xFFFFFFFF.
REQ-031 DIV A=0xFFFFFFF9 (-7), B=2 -> Y=0xFFFFFFFD; REM same operands -> Y=0xFFFFFFFF; DIVU A=100, B=7 -> Y=14; REMU same operands -> Y=2.
REQ-032 DIVU A=5, B=0 -> done at edge k+1, Y=0xFFFFFFFF; REMU A=5, B=0 -> Y=5; DIV A=0x80000000, B=0xFFFFFFFF -> done at k+1, Y=0x80000000; REM A=7, B=7 -> Y=0, zero=1.
REQ-033 Start with new operands while busy -> ignored; the first result and timing are unchanged; start held through DONE -> second operation accepted, done 34 cycles later.
REQ-034 Reset pulse at edge k+10 of a DIV -> busy=0, Y=0, zero=1 immediately; no done pulse; a subsequent MUL 3x4 completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: 32-cycle shift-add multiply or restoring
// divide on operand magnitudes, then one sign-fix cycle; divide-by-zero and signed overflow finish early.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  opcode,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] Y,
  output logic        zero
);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} stateType;

  stateType    state, nextState;
  logic [63:0] prod;
  logic [31:0] operand;
  logic [2:0]  op;
  logic [5:0]  count;
  logic        fast, negQ, negR;

  logic        accept, aSigned, bSigned, aNeg, bNeg;
  logic        divZero, divOvf, fastPath;
  logic [31:0] magA, magB, fastValue;

  // Operand decode at capture: magnitudes plus the sign flags needed later in FIX
  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign aSigned   = (opcode == 3'b001) || (opcode == 3'b010) || (opcode == 3'b100) || (opcode == 3'b110);
  assign bSigned   = (opcode == 3'b001) || (opcode == 3'b100) || (opcode == 3'b110);
  assign aNeg      = aSigned && A[31];
  assign bNeg      = bSigned && B[31];
  assign magA      = aNeg ? (~A + 32'd1) : A;
  assign magB      = bNeg ? (~B + 32'd1) : B;
  assign divZero   = opcode[2] && (B == 32'd0);
  assign divOvf    = opcode[2] && !opcode[0] && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign fastPath  = divZero || divOvf;
  assign fastValue = divZero ? (opcode[1] ? A : 32'hFFFF_FFFF)
                             : (opcode[1] ? 32'd0 : 32'h8000_0000);

  logic [32:0] mulSum, divShift, divDiff;
  logic        divFits;
  logic [63:0] prodFixed;
  logic [31:0] remFixed, fixResult;

  // prod holds {hi, lo}: product accumulator for multiply, {remainder, dividend/quotient} for divide
  assign mulSum   = {1'b0, prod[63:32]} + {1'b0, (prod[0] ? operand : 32'd0)};
  assign divShift = {prod[63:32], prod[31]};
  assign divDiff  = divShift - {1'b0, operand};
  assign divFits  = !divDiff[32];

  assign prodFixed = negQ ? (~prod + 64'd1) : prod;
  assign remFixed  = negR ? (~prod[63:32] + 32'd1) : prod[63:32];

  always_comb begin
    fixResult = remFixed;
    case (op)
      3'b000:                 fixResult = prodFixed[31:0];
      3'b001, 3'b010, 3'b011: fixResult = prodFixed[63:32];
      3'b100, 3'b101:         fixResult = prodFixed[31:0];
      default:                fixResult = remFixed;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // A start seen in DONE is taken directly, giving back-to-back operation
  always_comb begin
    nextState = state;
    case (state)
      IDLE, DONE: nextState = start ? (opcode[2] ? DIV : MUL) : IDLE;
      MUL:        if (count == 6'd31) nextState = FIX;
      DIV:        if (fast) nextState = DONE;
                  else if (count == 6'd31) nextState = FIX;
      FIX:        nextState = DONE;
      default:    nextState = IDLE;
    endcase
  end

  assign busy = (state == MUL) || (state == DIV) || (state == FIX);
  assign done = (state == DONE);

  // Fast-path results are parked in prod[31:0] at capture and copied to Y one edge later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod    <= 64'd0;
      operand <= 32'd0;
      op      <= 3'd0;
      count   <= 6'd0;
      fast    <= 1'b0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      Y       <= 32'd0;
      zero    <= 1'b1;
    end else if (accept) begin
      op      <= opcode;
      count   <= 6'd0;
      fast    <= fastPath;
      negQ    <= aNeg ^ bNeg;
      negR    <= aNeg;
      operand <= magB;
      prod    <= {32'd0, (fastPath ? fastValue : magA)};
    end else begin
      case (state)
        MUL: begin
          prod  <= {mulSum, prod[31:1]};
          count <= count + 6'd1;
        end
        DIV: begin
          if (fast) begin
            Y    <= prod[31:0];
            zero <= (prod[31:0] == 32'd0);
          end else begin
            prod  <= {(divFits ? divDiff[31:0] : divShift[31:0]), prod[30:0], divFits};
            count <= count + 6'd1;
          end
        end
        FIX: begin
          Y    <= fixResult;
          zero <= (fixResult == 32'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against a plain-arithmetic RV32M model.
module tb_muldiv_unit;

  logic        clk, reset, start;
  logic [2:0]  opcode;
  logic [31:0] A, B, Y;
  logic        busy, done, zero;

  int vectors = 0;
  int miscompares = 0;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .A(A), .B(B), .busy(busy), .done(done), .Y(Y), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result straight from the RV32M definitions using 64-bit arithmetic
  function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    r  = 32'd0;
    case (op)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int expLatency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && ((b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pickOperand();
    int sel;
    sel = $urandom_range(0, 7);
    case (sel)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // Issues one operation from idle, scrambles inputs after capture, returns result and edges-to-done
  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] y, output logic z, output int lat);
    @(posedge clk); #1;
    start = 1'b1; opcode = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; opcode = 3'($urandom); A = $urandom; B = $urandom;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    y = Y;
    z = zero;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; opcode = 3'd0; A = 32'd0; B = 32'd0;
    @(posedge clk); @(posedge clk); #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    vectors++; if (Y !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_y: got %h expected 0", Y); end
    vectors++; if (zero !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_zero: got %b expected 1", zero); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_directed();
    localparam int N = 14;
    localparam logic [2:0]  DOP [N] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                        3'd5, 3'd7, 3'd4, 3'd6, 3'd6, 3'd0};
    localparam logic [31:0] DA  [N] = '{32'd3, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                                        32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                        32'd5, 32'd5, 32'h8000_0000, 32'd7, 32'h8000_0000, 32'd0};
    localparam logic [31:0] DB  [N] = '{32'd4, 32'h8000_0000, 32'h8000_0000, 32'd2,
                                        32'd2, 32'd2, 32'd7, 32'd7,
                                        32'd0, 32'd0, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF, 32'd5};
    localparam logic [31:0] DY  [N] = '{32'h0000_000C, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF,
                                        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                        32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd0, 32'd0};
    localparam int          DL  [N] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 33, 1, 33};
    logic [31:0] y;
    logic        z;
    int          lat;
    for (int i = 0; i < N; i++) begin
      runOp(DOP[i], DA[i], DB[i], y, z, lat);
      vectors++; if (y !== DY[i]) begin miscompares++; $display("[TB] FAIL directed_y[%0d]: got %h expected %h", i, y, DY[i]); end
      vectors++; if (z !== (DY[i] == 32'd0)) begin miscompares++; $display("[TB] FAIL directed_zero[%0d]: got %b expected %b", i, z, DY[i] == 32'd0); end
      vectors++; if (lat !== DL[i]) begin miscompares++; $display("[TB] FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, DL[i]); end
    end
  endtask

  task automatic test_random(input logic isDivide, input int count);
    logic [2:0]  op;
    logic [31:0] a, b, expY, y;
    logic        z;
    int          lat, expLat;
    for (int i = 0; i < count; i++) begin
      op = {isDivide, 2'($urandom_range(0, 3))};
      a = pickOperand();
      b = pickOperand();
      expY = refModel(op, a, b);
      expLat = expLatency(op, a, b);
      runOp(op, a, b, y, z, lat);
      vectors++; if (y !== expY) begin miscompares++; $display("[TB] FAIL random_y op=%0d a=%h b=%h: got %h expected %h", op, a, b, y, expY); end
      vectors++; if (z !== (expY == 32'd0)) begin miscompares++; $display("[TB] FAIL random_zero op=%0d: got %b expected %b", op, z, expY == 32'd0); end
      vectors++; if (lat !== expLat) begin miscompares++; $display("[TB] FAIL random_latency op=%0d a=%h b=%h: got %0d expected %0d", op, a, b, lat, expLat); end
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] yBefore;
    int          lat;
    logic        sawDone;
    @(posedge clk); #1;
    start = 1'b1; opcode = 3'd0; A = 32'd3; B = 32'd4;
    @(posedge clk); #1;
    start = 1'b0; yBefore = Y;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL ignore_busy_after_accept: got %b expected 1", busy); end
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
      if (n == 16) begin
        vectors++; if (Y !== yBefore) begin miscompares++; $display("[TB] FAIL ignore_y_hold: got %h expected %h", Y, yBefore); end
      end
      start = (n >= 2) && (n <= 20);
      if (start) begin opcode = 3'($urandom); A = $urandom; B = $urandom; end
    end
    start = 1'b0;
    vectors++; if (lat !== 33) begin miscompares++; $display("[TB] FAIL ignore_latency: got %0d expected 33", lat); end
    vectors++; if (Y !== 32'h0000_000C) begin miscompares++; $display("[TB] FAIL ignore_y: got %h expected 0000000c", Y); end
    sawDone = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done || busy) sawDone = 1'b1;
    end
    vectors++; if (sawDone !== 1'b0) begin miscompares++; $display("[TB] FAIL ignore_not_queued: got %b expected 0", sawDone); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    @(posedge clk); #1;
    start = 1'b1; opcode = 3'd5; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    opcode = 3'd0; A = 32'd3; B = 32'd4;
    lat1 = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done) begin lat1 = n; break; end
    end
    vectors++; if (lat1 !== 33) begin miscompares++; $display("[TB] FAIL b2b_latency1: got %0d expected 33", lat1); end
    vectors++; if (Y !== 32'd14) begin miscompares++; $display("[TB] FAIL b2b_y1: got %h expected 0000000e", Y); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_busy_in_done: got %b expected 0", busy); end
    @(posedge clk); #1;
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_accept: got %b expected 1", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_done_pulse: got %b expected 0", done); end
    lat2 = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done) begin lat2 = n; break; end
    end
    vectors++; if (lat2 !== 33) begin miscompares++; $display("[TB] FAIL b2b_latency2: got %0d expected 33", lat2); end
    vectors++; if (Y !== 32'h0000_000C) begin miscompares++; $display("[TB] FAIL b2b_y2: got %h expected 0000000c", Y); end
    @(posedge clk); #1;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_single_done: got %b expected 0", done); end
  endtask

  task automatic test_reset_abort();
    int lat;
    @(posedge clk); #1;
    start = 1'b1; opcode = 3'd4; A = $urandom | 32'd1; B = $urandom | 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_done: got %b expected 0", done); end
    vectors++; if (Y !== 32'd0) begin miscompares++; $display("[TB] FAIL abort_y: got %h expected 0", Y); end
    vectors++; if (zero !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_zero: got %b expected 1", zero); end
    @(negedge clk);
    reset = 1'b0; start = 1'b1; opcode = 3'd0; A = 32'd3; B = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_first_edge_accept: got %b expected 1", busy); end
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    vectors++; if (lat !== 33) begin miscompares++; $display("[TB] FAIL abort_mul_latency: got %0d expected 33", lat); end
    vectors++; if (Y !== 32'h0000_000C) begin miscompares++; $display("[TB] FAIL abort_mul_y: got %h expected 0000000c", Y); end
    vectors++; if (zero !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_mul_zero: got %b expected 0", zero); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random(1'b0, 20);
    test_random(1'b1, 24);
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
